// File: rtl/delay_arbiter.sv
// -----------------------------------------------------------------------------
// delay_arbiter
//
// Shares one fixed-latency delay pipeline among N requesters. Each cycle a
// round-robin arbiter admits at most one request, tags it with the requester
// id and pushes it into a DEPTH-stage shift pipeline. The response emerges
// exactly DEPTH cycles later, with its id. A per-requester outstanding counter
// caps how many requests any one requester may have in flight at once.
//
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i].
// req_ready is combinational from req_valid and registered state, and is
// one-hot or zero. Requesters must not make req_valid depend on req_ready.
// Responses have no backpressure: rsp_valid is asserted for exactly one cycle
// per accepted request.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   req_valid  in   N      request valid, bit i = requester i
//   req_data   in   N*W    request data, requester i at [i*W +: W]
//   req_ready  out  N      combinational grant, at most one bit set
//   rsp_valid  out  1      response valid (registered)
//   rsp_id     out  IDW    requester id of response
//   rsp_data   out  W      delayed data
//   busy       out  1      any pipeline stage holds a valid entry
// -----------------------------------------------------------------------------
module delay_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int DEPTH   = 3,
  parameter int MAX_OUT = 2,
  localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic             busy
);

  // Counter width must be able to hold the value MAX_OUT itself.
  localparam int CW = (MAX_OUT > 0) ? $clog2(MAX_OUT + 1) : 1;

  // Increment an id modulo N without relying on N being a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int off);
    int s;
    s = int'(base) + off;
    while (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] r_ptr;                 // first index scanned next cycle
  logic [CW-1:0]  r_cnt      [N];        // in-flight requests per requester
  logic [DEPTH-1:0] r_stg_vld;           // stage valid bits, [DEPTH-1] = output
  logic [IDW-1:0] r_stg_id   [DEPTH];
  logic [W-1:0]   r_stg_data [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------------
  logic [N-1:0]   w_elig;
  logic           w_gnt_vld;
  logic [IDW-1:0] w_gnt_id;
  logic [W-1:0]   w_gnt_data;
  logic [IDW-1:0] w_cand;

  // Eligibility uses the registered count only. A requester at its limit
  // whose response is on the output this cycle stays ineligible until the
  // count actually drops at the next edge.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_elig[i] = req_valid[i] && (r_cnt[i] < CW'(MAX_OUT));
    end
  end

  // Scan ptr, ptr+1, ... mod N and pick the first eligible requester.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_id   = '0;
    w_gnt_data = '0;
    w_cand     = '0;
    req_ready  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = wrap_add(r_ptr, k);
      if (!w_gnt_vld && w_elig[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_cand;
      end
    end
    if (w_gnt_vld) begin
      req_ready[w_gnt_id] = 1'b1;
      w_gnt_data          = req_data[int'(w_gnt_id)*W +: W];
    end
  end

  // A grant is only ever issued to a valid requester, so grant == accept.
  logic w_accept;
  assign w_accept = w_gnt_vld;

  // ---------------------------------------------------------------------------
  // Round-robin pointer: moves past the winner on accept, holds otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= wrap_add(w_gnt_id, 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Delay pipeline. Stage 0 loads every cycle; a cycle with no accept shifts
  // in a bubble (valid=0, id/data zero). No stall path exists.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_stg_id[k]   <= '0;
        r_stg_data[k] <= '0;
      end
    end else begin
      r_stg_vld[0]  <= w_accept;
      r_stg_id[0]   <= w_gnt_id;
      r_stg_data[0] <= w_gnt_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_stg_vld[k]  <= r_stg_vld[k-1];
        r_stg_id[k]   <= r_stg_id[k-1];
        r_stg_data[k] <= r_stg_data[k-1];
      end
    end
  end

  assign rsp_valid = r_stg_vld[DEPTH-1];
  assign rsp_id    = r_stg_id[DEPTH-1];
  assign rsp_data  = r_stg_data[DEPTH-1];
  assign busy      = |r_stg_vld;

  // ---------------------------------------------------------------------------
  // Outstanding counters. A request leaves the count at the edge that ends
  // the cycle its response is presented. An accept and a retire for the same
  // requester on the same edge cancel out.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_cnt
    logic w_inc;
    logic w_dec;
    assign w_inc = w_accept && (w_gnt_id == IDW'(gi));
    assign w_dec = rsp_valid && (rsp_id == IDW'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt[gi] <= '0;
      end else begin
        case ({w_inc, w_dec})
          2'b10:   r_cnt[gi] <= r_cnt[gi] + CW'(1);
          2'b01:   r_cnt[gi] <= r_cnt[gi] - CW'(1);
          default: r_cnt[gi] <= r_cnt[gi];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_arbiter.sv
module tb_delay_arbiter;

  localparam int N       = 4;
  localparam int W       = 4;
  localparam int DEPTH   = 3;
  localparam int MAX_OUT = 2;
  localparam int IDW     = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;

  delay_arbiter #(.N(N), .W(W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ends one time unit after a rising edge, which is the start of cycle 0.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic           rst_first;
    logic [N-1:0]   vld;
    logic [N*W-1:0] data;
    logic [N-1:0]   rdy;
    logic           rv;
    logic [IDW-1:0] rid;
    logic [W-1:0]   rd;
    logic           bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                     input logic [N-1:0] y, input logic rv, input logic [IDW-1:0] rid,
                     input logic [W-1:0] rd, input logic b);
    vec_t e;
    e.rst_first = r; e.vld = v; e.data = d; e.rdy = y;
    e.rv = rv; e.rid = rid; e.rd = rd; e.bsy = b;
    tbl.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: list of in-flight requests with their due cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    int          id;
    logic [W-1:0] d;
  } flight_t;

  flight_t m_q[$];
  int      m_ptr;
  int      m_cyc;

  function automatic void model_reset();
    m_q.delete();
    m_ptr = 0;
    m_cyc = 0;
  endfunction

  function automatic int outstanding(input int id);
    int c = 0;
    foreach (m_q[j]) if (m_q[j].id == id && m_q[j].due >= m_cyc) c++;
    return c;
  endfunction

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i] && outstanding(i) < MAX_OUT) return i;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Single request from req0.
    add(1, 4'b0001, 16'h000A, 4'b0001, 0, 0, 0, 0);
    add(0, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 16'h0000, 4'b0000, 1, 0, 4'hA, 1);
    add(0, 4'b0000, 16'h0000, 4'b0000, 0, 0, 0, 0);
    // All four requesters continuously, data = id.
    add(1, 4'b1111, 16'h3210, 4'b0001, 0, 0, 0, 0);
    add(0, 4'b1111, 16'h3210, 4'b0010, 0, 0, 0, 1);
    add(0, 4'b1111, 16'h3210, 4'b0100, 0, 0, 0, 1);
    add(0, 4'b1111, 16'h3210, 4'b1000, 1, 0, 0, 1);
    add(0, 4'b1111, 16'h3210, 4'b0001, 1, 1, 1, 1);
    add(0, 4'b1111, 16'h3210, 4'b0010, 1, 2, 2, 1);
    add(0, 4'b1111, 16'h3210, 4'b0100, 1, 3, 3, 1);
    // Only req2, limited by MAX_OUT.
    add(1, 4'b0100, 16'h0500, 4'b0100, 0, 0, 0, 0);
    add(0, 4'b0100, 16'h0500, 4'b0100, 0, 0, 0, 1);
    add(0, 4'b0100, 16'h0500, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0100, 16'h0500, 4'b0000, 1, 2, 5, 1);
    add(0, 4'b0100, 16'h0500, 4'b0100, 1, 2, 5, 1);
    add(0, 4'b0100, 16'h0500, 4'b0100, 0, 0, 0, 1);
    add(0, 4'b0100, 16'h0500, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0100, 16'h0500, 4'b0000, 1, 2, 5, 1);
    add(0, 4'b0100, 16'h0500, 4'b0100, 1, 2, 5, 1);
    // Pointer wrap: grant 3, then 0 over 3, then 3.
    add(1, 4'b1000, 16'h9007, 4'b1000, 0, 0, 0, 0);
    add(0, 4'b1001, 16'h9007, 4'b0001, 0, 0, 0, 1);
    add(0, 4'b1001, 16'h9007, 4'b1000, 0, 0, 0, 1);
    add(0, 4'b0000, 16'h9007, 4'b0000, 1, 3, 9, 1);
    add(0, 4'b0000, 16'h9007, 4'b0000, 1, 0, 7, 1);
    add(0, 4'b0000, 16'h9007, 4'b0000, 1, 3, 9, 1);
    add(0, 4'b0000, 16'h9007, 4'b0000, 0, 0, 0, 0);
    // Accept and retire of req1 on the same edge leave its count at 1.
    add(1, 4'b0010, 16'h00B0, 4'b0010, 0, 0, 0, 0);
    add(0, 4'b0000, 16'h00B0, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 16'h00B0, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0010, 16'h00B0, 4'b0010, 1, 1, 4'hB, 1);
    add(0, 4'b0010, 16'h00B0, 4'b0010, 0, 0, 0, 1);
    add(0, 4'b0010, 16'h00B0, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 16'h00B0, 4'b0000, 1, 1, 4'hB, 1);
    add(0, 4'b0000, 16'h00B0, 4'b0000, 1, 1, 4'hB, 1);
    add(0, 4'b0000, 16'h00B0, 4'b0000, 0, 0, 0, 0);

    // Values while reset is held.
    #2;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_id",    32'(rsp_id),    32'd0);
    chk("reset rsp_data",  32'(rsp_data),  32'd0);
    chk("reset busy",      32'(busy),      32'd0);

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst_first) do_reset();
      else next_cycle();
      req_valid = tbl[r].vld;
      req_data  = tbl[r].data;
      @(negedge clk);
      chk($sformatf("row%0d ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rv));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].bsy));
      if (tbl[r].rv) begin
        chk($sformatf("row%0d rsp_id", r), 32'(rsp_id), 32'(tbl[r].rid));
        chk($sformatf("row%0d rsp_data", r), 32'(rsp_data), 32'(tbl[r].rd));
      end
    end

    // Reset in the middle of traffic drops everything in flight.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    next_cycle();
    next_cycle();
    #2;
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid-rst busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    req_valid = '0;
    for (int c = 0; c < DEPTH + 3; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst c%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("post-rst c%0d busy", c), 32'(busy), 32'd0);
    end
    next_cycle();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("post-rst ptr ready", 32'(req_ready), 32'b0001);
    // Two back-to-back accepts from req2 prove its count restarted at zero.
    next_cycle();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("post-rst cnt2 a", 32'(req_ready), 32'b0100);
    next_cycle();
    @(negedge clk);
    chk("post-rst cnt2 b", 32'(req_ready), 32'b0100);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      int g;
      logic [N-1:0] exp_rdy;
      logic         exp_rv;
      logic [IDW-1:0] exp_id;
      logic [W-1:0] exp_d;
      logic         exp_busy;
      if (c != 0) next_cycle();
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_data  = (N*W)'($urandom);
      g = model_grant(req_valid);
      exp_rdy  = (g >= 0) ? N'(1 << g) : '0;
      exp_rv   = 1'b0;
      exp_id   = '0;
      exp_d    = '0;
      exp_busy = 1'b0;
      foreach (m_q[j]) begin
        if (m_q[j].due >= m_cyc) exp_busy = 1'b1;
        if (m_q[j].due == m_cyc) begin
          exp_rv = 1'b1;
          exp_id = IDW'(m_q[j].id);
          exp_d  = m_q[j].d;
        end
      end
      @(negedge clk);
      chk($sformatf("rnd%0d ready", c), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("rnd%0d rsp_valid", c), 32'(rsp_valid), 32'(exp_rv));
      chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(exp_busy));
      if (exp_rv) begin
        chk($sformatf("rnd%0d rsp_id", c), 32'(rsp_id), 32'(exp_id));
        chk($sformatf("rnd%0d rsp_data", c), 32'(rsp_data), 32'(exp_d));
      end
      if (g >= 0) begin
        flight_t f;
        f.due = m_cyc + DEPTH;
        f.id  = g;
        f.d   = req_data[g*W +: W];
        m_q.push_back(f);
        m_ptr = (g + 1) % N;
      end
      for (int j = m_q.size() - 1; j >= 0; j--) begin
        if (m_q[j].due <= m_cyc) m_q.delete(j);
      end
      m_cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
